// File: rtl/gmsk_pkg.sv
// Shared definitions for the GMSK-P1 fetch-stage program counter.
package gmsk_pkg;

    // Default address width and instruction size.
    localparam int XLEN_DEF       = 32;
    localparam int INSN_BYTES_DEF = 4;
    localparam int RAS_DEPTH_DEF  = 4;

    // Architectural vectors.
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    // Program-counter control state.
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

endpackage : gmsk_pkg

// File: rtl/return_addr_stack.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry, and the occupancy count saturates at DEPTH. A pop has priority
// over a push if both arrive together. Clear empties the stack.
module return_addr_stack #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]   top_ptr_q;
    logic [PW-1:0]   top_ptr_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            do_pop;
    logic            do_push;
    logic [PW-1:0]   ptr_inc;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign top     = mem_q[top_ptr_q];
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && !pop && !clear;
    assign ptr_inc = top_ptr_q + PW'(1);

    // Next pointer and occupancy for push, pop and clear.
    always_comb begin
        top_ptr_d = top_ptr_q;
        count_d   = count_q;
        if (clear) begin
            top_ptr_d = '0;
            count_d   = '0;
        end else if (do_pop) begin
            top_ptr_d = top_ptr_q - PW'(1);
            count_d   = count_q - CW'(1);
        end else if (do_push) begin
            top_ptr_d = ptr_inc;
            if (!full) begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            top_ptr_q <= top_ptr_d;
            count_q   <= count_d;
        end
    end

    // Entry storage; a push lands one slot above the current top.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[ptr_inc] <= push_data;
        end
    end

endmodule : return_addr_stack

// File: rtl/pc_unit.sv
// Fetch-stage program counter with trap/return/redirect/RAS selection,
// halt/resume control and misaligned-target detection.
//
// Handshake: pc is offered when pc_valid is high; a transfer (fire) happens
// on a rising edge where pc_valid && pc_ready. pc and pc_valid come only from
// registers, so pc_ready never combinationally affects them. Trap entry,
// trap return and redirects act without waiting for pc_ready; hints are only
// considered on fire.
module pc_unit
    import gmsk_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
    parameter int              INSN_BYTES   = INSN_BYTES_DEF,
    parameter int              RAS_DEPTH    = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    input  logic            pc_ready,
    input  logic            call_hint,
    input  logic            ret_hint,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_req,
    input  logic            trap_ret,
    input  logic            halt,
    input  logic            resume,
    output logic [XLEN-1:0] epc,
    output logic            misaligned_fault,
    output logic            ras_underflow,
    output pc_state_t       state_dbg,
    output logic            ras_empty_dbg,
    output logic            ras_full_dbg
);

    localparam logic [XLEN-1:0] INC_AMT    = XLEN'(INSN_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSN_BYTES - 1);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            pc_valid_q;
    logic            misaligned_q, misaligned_d;
    logic            underflow_q, underflow_d;

    logic            fire;
    logic [XLEN-1:0] pc_inc;
    logic            target_aligned;

    logic            ras_push;
    logic            ras_pop;
    logic            ras_clear;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full;

    assign fire           = pc_valid_q && pc_ready;
    assign pc_inc         = pc_q + INC_AMT;
    assign target_aligned = ((redirect_target & ALIGN_MASK) == '0);

    return_addr_stack #(
        .DEPTH (RAS_DEPTH),
        .XLEN  (XLEN)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .clear     (ras_clear),
        .push_data (pc_inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // Next-state, next-PC and RAS control; one action per cycle by priority.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        epc_d        = epc_q;
        misaligned_d = 1'b0;
        underflow_d  = 1'b0;
        ras_push     = 1'b0;
        ras_pop      = 1'b0;
        ras_clear    = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (trap_req) begin
                    pc_d      = TRAP_VECTOR;
                    epc_d     = pc_q;
                    ras_clear = 1'b1;
                end else if (trap_ret) begin
                    pc_d = epc_q;
                end else if (redirect_valid) begin
                    if (target_aligned) begin
                        pc_d = redirect_target;
                    end else begin
                        pc_d         = TRAP_VECTOR;
                        epc_d        = pc_q;
                        misaligned_d = 1'b1;
                    end
                end else if (fire) begin
                    if (ret_hint) begin
                        if (!ras_empty) begin
                            pc_d    = ras_top;
                            ras_pop = 1'b1;
                        end else begin
                            pc_d        = pc_inc;
                            underflow_d = 1'b1;
                        end
                    end else begin
                        pc_d     = pc_inc;
                        ras_push = call_hint;
                    end
                end
                if (halt) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                // A trap pulls the core out of halt through the trap vector.
                if (trap_req) begin
                    pc_d      = TRAP_VECTOR;
                    epc_d     = pc_q;
                    ras_clear = 1'b1;
                    state_d   = RUN;
                end else if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and registered outputs; reset wins over every other condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            pc_valid_q   <= 1'b0;
            misaligned_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            pc_valid_q   <= (state_d == RUN);
            misaligned_q <= misaligned_d;
            underflow_q  <= underflow_d;
        end
    end

    assign pc               = pc_q;
    assign pc_valid         = pc_valid_q;
    assign epc              = epc_q;
    assign misaligned_fault = misaligned_q;
    assign ras_underflow    = underflow_q;
    assign state_dbg        = state_q;
    assign ras_empty_dbg    = ras_empty;
    assign ras_full_dbg     = ras_full;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset/boot, stall, redirect, trap priority,
// misaligned redirect, RAS overflow/underflow, halt/resume, wrap.
module tb_pc_unit;
    import gmsk_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        call_hint;
    logic        ret_hint;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_req;
    logic        trap_ret;
    logic        halt;
    logic        resume;
    logic [31:0] epc;
    logic        misaligned_fault;
    logic        ras_underflow;
    pc_state_t   state_dbg;
    logic        ras_empty_dbg;
    logic        ras_full_dbg;

    int tests_run;
    int tests_failed;

    pc_unit dut (
        .clk              (clk),
        .rst              (rst),
        .pc               (pc),
        .pc_valid         (pc_valid),
        .pc_ready         (pc_ready),
        .call_hint        (call_hint),
        .ret_hint         (ret_hint),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .trap_req         (trap_req),
        .trap_ret         (trap_ret),
        .halt             (halt),
        .resume           (resume),
        .epc              (epc),
        .misaligned_fault (misaligned_fault),
        .ras_underflow    (ras_underflow),
        .state_dbg        (state_dbg),
        .ras_empty_dbg    (ras_empty_dbg),
        .ras_full_dbg     (ras_full_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        pc_ready        = 1'b0;
        call_hint       = 1'b0;
        ret_hint        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        trap_req        = 1'b0;
        trap_ret        = 1'b0;
        halt            = 1'b0;
        resume          = 1'b0;
    endtask

    // Redirect while stalled so pc lands exactly on target.
    task automatic jump_to(input logic [31:0] tgt);
        idle_inputs();
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        step();
        idle_inputs();
    endtask

    logic [31:0] call_pcs [5];
    logic [31:0] ret_exp  [4];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        idle_inputs();
        rst = 1'b1;
        step();
        step();

        // Reset state
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'b0, pc_valid}, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_state", 32'(state_dbg), 32'(BOOT));
        check("rst_mis", {31'b0, misaligned_fault}, 32'h0);
        check("rst_unf", {31'b0, ras_underflow}, 32'h0);
        check("rst_ras_empty", {31'b0, ras_empty_dbg}, 32'h1);

        // Boot: valid low one cycle, then sequential fetch
        rst = 1'b0;
        pc_ready = 1'b1;
        step();
        check("boot_state", 32'(state_dbg), 32'(RUN));
        check("boot_valid", {31'b0, pc_valid}, 32'h1);
        check("seq_pc0", pc, 32'h0);
        step();
        check("seq_pc4", pc, 32'h4);
        step();
        check("seq_pc8", pc, 32'h8);

        // Stall holds pc
        pc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 32'h8);
        end
        step();
        pc_ready = 1'b1;
        step();
        check("seq_pcc", pc, 32'hC);

        // Redirect during stall
        jump_to(32'h40);
        check("redir_pc", pc, 32'h40);
        pc_ready = 1'b1;
        step();
        check("redir_inc", pc, 32'h44);

        // Trap beats redirect and hints
        jump_to(32'h20);
        pc_ready        = 1'b1;
        trap_req        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        ret_hint        = 1'b1;
        step();
        idle_inputs();
        check("trap_pc", pc, 32'h100);
        check("trap_epc", epc, 32'h20);
        trap_ret = 1'b1;
        step();
        idle_inputs();
        check("tret_pc", pc, 32'h20);

        // Misaligned redirect
        redirect_valid  = 1'b1;
        redirect_target = 32'h42;
        step();
        idle_inputs();
        check("mis_pc", pc, 32'h100);
        check("mis_epc", epc, 32'h20);
        check("mis_pulse", {31'b0, misaligned_fault}, 32'h1);
        step();
        check("mis_clear", {31'b0, misaligned_fault}, 32'h0);

        // RAS: five calls into a 4-deep stack
        call_pcs = '{32'h10, 32'h50, 32'h90, 32'hD0, 32'h110};
        ret_exp  = '{32'h114, 32'hD4, 32'h94, 32'h54};
        for (int i = 0; i < 5; i++) begin
            jump_to(call_pcs[i]);
            pc_ready  = 1'b1;
            call_hint = 1'b1;
            step();
            idle_inputs();
            check("call_pc", pc, call_pcs[i] + 32'h4);
        end
        check("ras_full", {31'b0, ras_full_dbg}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            pc_ready = 1'b1;
            ret_hint = 1'b1;
            step();
            idle_inputs();
            check("ret_pc", pc, ret_exp[i]);
            check("ret_no_unf", {31'b0, ras_underflow}, 32'h0);
        end
        check("ras_empty", {31'b0, ras_empty_dbg}, 32'h1);
        pc_ready = 1'b1;
        ret_hint = 1'b1;
        step();
        idle_inputs();
        check("unf_pc", pc, 32'h58);
        check("unf_pulse", {31'b0, ras_underflow}, 32'h1);
        step();
        check("unf_clear", {31'b0, ras_underflow}, 32'h0);

        // Halt with a call: update still happens, then HALTED
        pc_ready  = 1'b1;
        call_hint = 1'b1;
        halt      = 1'b1;
        step();
        idle_inputs();
        pc_ready = 1'b1;
        check("halt_pc", pc, 32'h5C);
        check("halt_state", 32'(state_dbg), 32'(HALTED));
        check("halt_valid", {31'b0, pc_valid}, 32'h0);
        check("halt_ras", {31'b0, ras_empty_dbg}, 32'h0);
        step();
        check("halt_frozen", pc, 32'h5C);
        resume = 1'b1;
        step();
        idle_inputs();
        check("resume_state", 32'(state_dbg), 32'(RUN));
        check("resume_pc", pc, 32'h5C);
        halt = 1'b1;
        step();
        idle_inputs();
        check("halt2_state", 32'(state_dbg), 32'(HALTED));

        // Reset while halted
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("hrst_pc", pc, 32'h0);
        check("hrst_state", 32'(state_dbg), 32'(BOOT));
        check("hrst_ras", {31'b0, ras_empty_dbg}, 32'h1);
        check("hrst_valid", {31'b0, pc_valid}, 32'h0);
        step();
        check("hrst_run", 32'(state_dbg), 32'(RUN));

        // Wrap at top of address space
        jump_to(32'hFFFF_FFFC);
        check("wrap_pre", pc, 32'hFFFF_FFFC);
        pc_ready = 1'b1;
        step();
        check("wrap_pc", pc, 32'h0);
        step();
        check("wrap_inc", pc, 32'h4);

        // Trap leaves HALTED
        idle_inputs();
        halt = 1'b1;
        step();
        idle_inputs();
        check("halt3_state", 32'(state_dbg), 32'(HALTED));
        trap_req = 1'b1;
        step();
        idle_inputs();
        check("htrap_pc", pc, 32'h100);
        check("htrap_epc", epc, 32'h4);
        check("htrap_state", 32'(state_dbg), 32'(RUN));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_pc_unit
